// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared FSM state encoding and default timing for button_debouncer
// Used by button_debouncer and button_debouncer_channel (optional feature macro: DEBOUNCE_AUTOREPEAT_EN).
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    S_RELEASED     = 2'b00,
    S_PRESS_PEND   = 2'b01,
    S_PRESSED      = 2'b11,
    S_RELEASE_PEND = 2'b10
  } btn_state_t;

  // Defaults assume a 12 MHz clock: 10 ms debounce, 500 ms repeat delay, 100 ms repeat period
  localparam int DEF_NUM_BTNS      = 2;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 120000;
  localparam int DEF_REPEAT_DELAY  = 6000000;
  localparam int DEF_REPEAT_PERIOD = 1200000;

endpackage

// File: rtl/button_debouncer_channel.sv
// rtl/button_debouncer_channel.sv - one-bit synchroniser, debounce FSM and counters
// Auto-repeat hold counter is built only when DEBOUNCE_AUTOREPEAT_EN is defined.
module button_debouncer_channel
  import button_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
`ifdef DEBOUNCE_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_stb,
  output logic release_stb
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  btn_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_d, press_d, release_d;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic [HW-1:0] HOLD_DLY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_PER_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_q, hold_d, hold_last;
  logic          rep_q, rep_d;

  // rep_q selects the repeat period once the initial delay has fired
  assign hold_last = rep_q ? HOLD_PER_LAST : HOLD_DLY_LAST;
`endif

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      state_q     <= S_RELEASED;
      cnt_q       <= '0;
      level       <= 1'b1;
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], raw};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level       <= level_d;
      press_stb   <= press_d;
      release_stb <= release_d;
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    hold_d    = hold_q;
    rep_d     = rep_q;
`endif
    case (state_q)
      S_RELEASED: begin
        if (!s) begin
          state_d = S_PRESS_PEND;
          cnt_d   = '0;
        end
      end
      S_PRESS_PEND: begin
        if (s) begin
          state_d = S_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
          level_d = 1'b0;
          press_d = 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
          hold_d  = '0;
          rep_d   = 1'b0;
`endif
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PRESSED: begin
        if (s) begin
          state_d = S_RELEASE_PEND;
          cnt_d   = '0;
        end
`ifdef DEBOUNCE_AUTOREPEAT_EN
        else if (hold_q == hold_last) begin
          press_d = 1'b1;
          hold_d  = '0;
          rep_d   = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      S_RELEASE_PEND: begin
        // Hold counter is left untouched here so a bounce back to pressed resumes the repeat timing
        if (!s) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_RELEASED;
          cnt_d     = '0;
          level_d   = 1'b1;
          release_d = 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
          hold_d    = '0;
          rep_d     = 1'b0;
`endif
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - debounces NUM_BTNS active-low pushbuttons into levels and press/release strobes
// Optional auto-repeat of btn_press while held: define DEBOUNCE_AUTOREPEAT_EN.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int NUM_BTNS      = DEF_NUM_BTNS,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                rst_btn,
  input  logic [NUM_BTNS-1:0] pmod,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release
);

  generate
    if (NUM_BTNS < 1 || SYNC_STAGES < 2 || STABLE_CYCLES < 2 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("button_debouncer: parameter out of range");
    end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
      button_debouncer_channel #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
`ifdef DEBOUNCE_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
      ) u_ch (
        .clk         (clk),
        .rst_n       (rst_btn),
        .raw         (pmod[i]),
        .level       (btn_level[i]),
        .press_stb   (btn_press[i]),
        .release_stb (btn_release[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed table-driven bench for button_debouncer
// Expectations for held-button repeats follow DEBOUNCE_AUTOREPEAT_EN.
module tb_button_debouncer;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_btn;
  logic [1:0] pmod;
  logic [1:0] btn_level, btn_press, btn_release;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] pmod;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
  } vec_t;

  vec_t vq[$];

  button_debouncer #(
    .NUM_BTNS      (2),
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) dut (
    .clk         (clk),
    .rst_btn     (rst_btn),
    .pmod        (pmod),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [1:0] el, input logic [1:0] ep, input logic [1:0] er);
    checks++;
    if ({btn_level, btn_press, btn_release} !== {el, ep, er}) begin
      failures++;
      $display("FAIL %s[%0d]: got level=%b press=%b release=%b, want level=%b press=%b release=%b",
               name, idx, btn_level, btn_press, btn_release, el, ep, er);
    end
  endtask

  task automatic add(input int n, input logic [1:0] p, input logic [1:0] l,
                     input logic [1:0] pr, input logic [1:0] r);
    vec_t v;
    v.pmod  = p;
    v.level = l;
    v.press = pr;
    v.rel   = r;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vq.size(); i++) begin
      pmod = vq[i].pmod;
      tick();
      check(name, i, vq[i].level, vq[i].press, vq[i].rel);
    end
    vq.delete();
  endtask

  initial begin
    logic [1:0] el, ep, er;

    // Reset held with both buttons pressed: outputs stay idle
    rst_btn = 1'b0;
    pmod    = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset", i, 2'b11, 2'b00, 2'b00);
    end
    pmod    = 2'b11;
    rst_btn = 1'b1;
    add(10, 2'b11, 2'b11, 2'b00, 2'b00);
    run_table("idle_after_reset");

    // Bounce on ch0 shorter than the debounce window
    add(3, 2'b10, 2'b11, 2'b00, 2'b00);
    add(1, 2'b11, 2'b11, 2'b00, 2'b00);
    add(3, 2'b10, 2'b11, 2'b00, 2'b00);
    add(5, 2'b11, 2'b11, 2'b00, 2'b00);
    run_table("bounce_ch0");

    // Clean press ch0: level changes on the 7th edge with a single press strobe
    add(6, 2'b10, 2'b11, 2'b00, 2'b00);
    add(1, 2'b10, 2'b10, 2'b01, 2'b00);
    add(1, 2'b10, 2'b10, 2'b00, 2'b00);
    run_table("press_ch0");

    // Clean release ch0
    add(6, 2'b11, 2'b10, 2'b00, 2'b00);
    add(1, 2'b11, 2'b11, 2'b00, 2'b01);
    add(1, 2'b11, 2'b11, 2'b00, 2'b00);
    run_table("release_ch0");

    // Press again, then release with a one-cycle low glitch during the pending window
    add(6, 2'b10, 2'b11, 2'b00, 2'b00);
    add(1, 2'b10, 2'b10, 2'b01, 2'b00);
    add(1, 2'b10, 2'b10, 2'b00, 2'b00);
    add(2, 2'b11, 2'b10, 2'b00, 2'b00);
    add(1, 2'b10, 2'b10, 2'b00, 2'b00);
    add(6, 2'b11, 2'b10, 2'b00, 2'b00);
    add(1, 2'b11, 2'b11, 2'b00, 2'b01);
    add(1, 2'b11, 2'b11, 2'b00, 2'b00);
    run_table("release_glitch_ch0");

    // Both channels pressed and released in the same cycle
    add(6, 2'b00, 2'b11, 2'b00, 2'b00);
    add(1, 2'b00, 2'b00, 2'b11, 2'b00);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(6, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 2'b11, 2'b11, 2'b00, 2'b11);
    add(1, 2'b11, 2'b11, 2'b00, 2'b00);
    run_table("both");

    // ch1 pressed, ch0 left pending, then asynchronous reset between edges
    add(6, 2'b01, 2'b11, 2'b00, 2'b00);
    add(1, 2'b01, 2'b01, 2'b10, 2'b00);
    add(1, 2'b01, 2'b01, 2'b00, 2'b00);
    run_table("press_ch1");
    add(4, 2'b00, 2'b01, 2'b00, 2'b00);
    run_table("pend_ch0");
    #2;
    rst_btn = 1'b0;
    #1;
    check("async_reset", 0, 2'b11, 2'b00, 2'b00);
    pmod = 2'b11;
    tick();
    tick();
    rst_btn = 1'b1;
    add(10, 2'b11, 2'b11, 2'b00, 2'b00);
    run_table("after_mid_reset");

    // Long hold on ch1: repeats at +10, +13, ... only with auto-repeat
    add(6, 2'b01, 2'b11, 2'b00, 2'b00);
    run_table("hold_pend_ch1");
    for (int k = 0; k <= 28; k++) begin
      tick();
      ep = ((k == 0) || (AR && k >= 10 && ((k - 10) % 3) == 0)) ? 2'b10 : 2'b00;
      check("hold_ch1", k, 2'b01, ep, 2'b00);
    end
    pmod = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      tick();
      el = (i >= 7) ? 2'b11 : 2'b01;
      er = (i == 7) ? 2'b10 : 2'b00;
      check("hold_release_ch1", i, el, 2'b00, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
